// File: rtl/handshake_fifo_buffer.sv
// Elastic DEPTH-slot FIFO buffer between valid/ready handshake stages.
// Optional zero-latency fast path when empty: define HANDSHAKE_FIFO_BYPASS_EN.
module handshake_fifo_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic empty;
    logic full;
    logic bypass;
    logic push;
    logic pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL);
    assign ins_ready = ~full;

`ifdef HANDSHAKE_FIFO_BYPASS_EN
    // Empty buffer with both sides willing: hand the token straight through.
    assign bypass     = empty & ins_valid & outs_ready;
    assign outs_valid = ~empty | ins_valid;
    assign outs       = empty ? ins : mem_q[rd_ptr_q];
`else
    assign bypass     = 1'b0;
    assign outs_valid = ~empty;
    assign outs       = mem_q[rd_ptr_q];
`endif

    assign push = ins_valid & ins_ready & ~bypass;
    assign pop  = outs_valid & outs_ready & ~empty;

    // Explicit wrap keeps non-power-of-two depths in range.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= ins;
        end
    end

    a_count_bound: assert property (
        @(posedge clk) disable iff (!rst) count_q <= FULL
    );
    a_no_push_full: assert property (
        @(posedge clk) disable iff (!rst) !(push && full)
    );
    a_no_pop_empty: assert property (
        @(posedge clk) disable iff (!rst) !(pop && empty)
    );

endmodule

// File: tb/tb_handshake_fifo_buffer.sv
// Bench for handshake_fifo_buffer: queue models for DEPTH=4 and DEPTH=3
// instances plus directed literal expectations.
module tb_handshake_fifo_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] ins = '0;
    logic        ins_valid = 1'b0;
    logic        outs_ready = 1'b0;

    logic [31:0] o4, o3;
    logic        v4, v3, r4, r3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    handshake_fifo_buffer #(.DATA_WIDTH(32), .DEPTH(4)) u4 (
        .clk(clk), .rst(rst),
        .ins(ins), .ins_valid(ins_valid), .ins_ready(r4),
        .outs(o4), .outs_valid(v4), .outs_ready(outs_ready)
    );

    handshake_fifo_buffer #(.DATA_WIDTH(32), .DEPTH(3)) u3 (
        .clk(clk), .rst(rst),
        .ins(ins), .ins_valid(ins_valid), .ins_ready(r3),
        .outs(o3), .outs_valid(v3), .outs_ready(outs_ready)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference: contents of each buffer as a plain queue.
    logic [31:0] q4[$];
    logic [31:0] q3[$];

    always @(negedge rst) begin
        q4.delete();
        q3.delete();
    end

    always @(posedge clk) begin
        bit pu, po;
        if (rst) begin
            po = outs_ready && q4.size() != 0;
            pu = ins_valid && q4.size() != 4;
`ifdef HANDSHAKE_FIFO_BYPASS_EN
            if (q4.size() == 0 && outs_ready) pu = 0;
`endif
            if (po) void'(q4.pop_front());
            if (pu) q4.push_back(ins);

            po = outs_ready && q3.size() != 0;
            pu = ins_valid && q3.size() != 3;
`ifdef HANDSHAKE_FIFO_BYPASS_EN
            if (q3.size() == 0 && outs_ready) pu = 0;
`endif
            if (po) void'(q3.pop_front());
            if (pu) q3.push_back(ins);
        end
    end

    logic        pv4 = 0, pr4 = 0, pv3 = 0, pr3 = 0;
    logic [31:0] po4 = 0, po3 = 0;

    always @(negedge clk) begin
        logic        ev;
        logic [31:0] eo;
        if (!rst) begin
            pv4 = 0;
            pv3 = 0;
        end else begin
            ev = q4.size() != 0;
            eo = (q4.size() != 0) ? q4[0] : ins;
`ifdef HANDSHAKE_FIFO_BYPASS_EN
            ev = ev || ins_valid;
`endif
            chk("u4_ins_ready", r4, q4.size() != 4);
            chk("u4_outs_valid", v4, ev);
            if (ev) chk("u4_outs", o4, eo);
            if (pv4 && !pr4) begin
                chk("u4_hold_valid", v4, 1);
                chk("u4_hold_data", o4, po4);
            end
            pv4 = v4; pr4 = outs_ready; po4 = o4;

            ev = q3.size() != 0;
            eo = (q3.size() != 0) ? q3[0] : ins;
`ifdef HANDSHAKE_FIFO_BYPASS_EN
            ev = ev || ins_valid;
`endif
            chk("u3_ins_ready", r3, q3.size() != 3);
            chk("u3_outs_valid", v3, ev);
            if (ev) chk("u3_outs", o3, eo);
            if (pv3 && !pr3) begin
                chk("u3_hold_valid", v3, 1);
                chk("u3_hold_data", o3, po3);
            end
            pv3 = v3; pr3 = outs_ready; po3 = o3;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset then idle
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk("rst_outs_valid", v4, 0);
        chk("rst_ins_ready", r4, 1);
        chk("rst_outs", o4, 32'h0);
        chk("rst3_outs_valid", v3, 0);
        chk("rst3_outs", o3, 32'h0);
        tick();

        // Single token
        ins = 32'h77CBF1FA;
        ins_valid = 1;
        outs_ready = 1;
        tick();
        ins_valid = 0;
`ifndef HANDSHAKE_FIFO_BYPASS_EN
        chk("single_valid", v4, 1);
        chk("single_data", o4, 32'h77CBF1FA);
`endif
        tick();
        chk("single_drained", v4, 0);

        // Fill and backpressure
        outs_ready = 0;
        for (int i = 1; i <= 4; i++) begin
            ins = 32'(i);
            ins_valid = 1;
            tick();
        end
        chk("full_ready", r4, 0);
        chk("full3_ready", r3, 0);
        ins = 32'h5;
        tick();
        chk("full_ready_hold", r4, 0);
        ins_valid = 0;
        outs_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            if (i == 2) chk("ready_after_pop", r4, 1);
            chk("drain_valid", v4, 1);
            chk("drain_data", o4, 32'(i));
            tick();
        end
        chk("drain_empty", v4, 0);
        chk("drain3_empty", v3, 0);

        // Streaming with wrap on the DEPTH=3 instance
        ins_valid = 1;
        outs_ready = 1;
        for (int k = 0; k < 10; k++) begin
            ins = 32'hA0 + 32'(k);
            tick();
`ifndef HANDSHAKE_FIFO_BYPASS_EN
            chk("stream_valid", v3, 1);
            chk("stream_data", o3, 32'hA0 + 32'(k));
            chk("stream_ready", r3, 1);
`endif
        end
        ins_valid = 0;
        tick();
        chk("stream_end", v3, 0);

        // Random stall
        for (int n = 0; n < 1000; n++) begin
            ins = $urandom;
            ins_valid = 1'($urandom_range(0, 1));
            outs_ready = 1'($urandom_range(0, 1));
            tick();
        end
        ins_valid = 0;
        outs_ready = 1;
        repeat (6) tick();
        chk("random_drained4", v4, 0);
        chk("random_drained3", v3, 0);

        // Reset mid-stream
        outs_ready = 0;
        for (int i = 0; i < 3; i++) begin
            ins = 32'hBEEF0000 + 32'(i);
            ins_valid = 1;
            tick();
        end
        ins_valid = 0;
        chk("pre_rst_valid", v4, 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valid", v4, 0);
        chk("mid_rst_ready", r4, 1);
        chk("mid_rst3_valid", v3, 0);
        tick();
        rst = 1'b1;
        ins = 32'hDEAD0001;
        ins_valid = 1;
        outs_ready = 1;
        tick();
        ins_valid = 0;
`ifndef HANDSHAKE_FIFO_BYPASS_EN
        chk("post_rst_valid", v4, 1);
        chk("post_rst_data", o4, 32'hDEAD0001);
`endif
        tick();
        chk("post_rst_empty", v4, 0);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/handshake_fifo_buffer.md
Name: handshake_fifo_buffer

Overview:
- Elastic FIFO slot buffer placed directly downstream of handshake constant / operator stages in the dataflow netlist.
- Decouples the producer's valid/ready pair from the consumer's, breaking the combinational ready path from consumer to producer.
- Stores up to DEPTH tokens and delivers them in order with registered storage.
- Default operation is opaque: 1-cycle minimum latency.

Parameters:
- DATA_WIDTH, 32, token data width in bits.
- DEPTH, 4, number of token slots; legal range 2..16; need not be a power of two.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset (asserted when 0).
- ins  input  DATA_WIDTH  upstream token data.
- ins_valid  input  1  upstream token present.
- ins_ready  output  1  buffer can accept a token this cycle.
- outs  output  DATA_WIDTH  head-of-queue token data.
- outs_valid  output  1  head token present.
- outs_ready  input  1  downstream accepts the head token this cycle.

Behaviour:
- Storage: mem[0..DEPTH-1].
- Pointers: wr_ptr, rd_ptr, each $clog2(DEPTH) bits.
- Occupancy: count, $clog2(DEPTH+1) bits. All are registers.
- Reset (rst=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, all mem entries=0.
  - Outputs: outs_valid=0, ins_ready=1, outs=0.
- push = ins_valid & ins_ready; pop = outs_valid & outs_ready. Both are evaluated in the same cycle and take effect at the next rising edge.
- ins_ready = (count != DEPTH). It depends only on registered state; no combinational path from outs_ready.
- outs_valid = (count != 0). outs = mem[rd_ptr], a combinational read of registered storage.
- On push: mem[wr_ptr] <= ins; wr_ptr advances by 1 and wraps DEPTH-1 -> 0 explicitly (non-power-of-two safe).
- On pop: rd_ptr advances by 1 with the same wrap rule.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop, or on neither.
- Latency: a token pushed at edge N is visible on outs with outs_valid=1 from edge N+1.
- Full (count=DEPTH): ins_ready=0. A pop in this cycle does NOT enable a same-cycle push; ins_ready rises the cycle after the pop.
- Empty (count=0): outs_valid=0. The value on outs is don't-care to consumers but equals mem[rd_ptr] (stale data).
- Simultaneous push and pop at count=1: head is replaced by the new token next cycle; count stays 1.
- Ordering: strict FIFO; no token dropped or duplicated under any valid/ready pattern.
- Stability: outs and outs_valid are held stable while outs_valid=1 and outs_ready=0.
- Reset mid-operation: all buffered tokens are discarded immediately; state matches the post-reset values above.
- Assertions (simulation only):
  - count never exceeds DEPTH.
  - No push when count=DEPTH.
  - No pop when count=0.

Optional Feature:
- Macro: HANDSHAKE_FIFO_BYPASS_EN.
- When defined, adds a transparent fast path used when count=0, ins_valid=1 and outs_ready=1:
  - outs = ins and outs_valid = 1 in the same cycle, giving 0-cycle latency.
  - The token is consumed without being written; pointers and count are unchanged.
  - Outside that condition: outs_valid = (count!=0) | ins_valid, and outs selects ins when count=0.
  - ins_ready is unchanged; this still introduces no combinational path from outs_ready to ins_ready.
- When not defined, behaviour is purely opaque as described in Behaviour.

Test Plan:
1. Reset then idle: rst=0 for 3 cycles, release -> outs_valid=0, ins_ready=1, outs=0, count=0.
2. Single token: push 0x77CBF1FA at edge N with outs_ready=1 -> outs_valid=1 and outs=0x77CBF1FA at cycle N+1; outs_valid=0 at N+2 (bypass off).
3. Fill and backpressure: outs_ready=0, push 0x1,0x2,0x3,0x4, attempt 0x5 -> ins_ready=0 after the 4th push, 0x5 not accepted. Then outs_ready=1 -> outputs 0x1,0x2,0x3,0x4 in order; ins_ready=1 the cycle after the first pop.
4. Streaming with wrap: DEPTH=3, ins_valid=outs_ready=1 continuously, 10 tokens 0xA0..0xA9 -> all 10 emitted in order with 1-cycle latency, count steady at 1, both pointers wrap 2->0.
5. Random stall: random ins_valid/outs_ready for 1000 cycles against a scoreboard -> zero mismatches, outs held stable during every stall, no assertion fires.
6. Reset mid-stream: 3 tokens buffered, rst=0 pulse asynchronous between edges -> outs_valid drops to 0 immediately, ins_ready=1. The next push, 0xDEAD0001, is the first token out.
